// File: rtl/frame_scheduler.sv
// frame_scheduler: per-frame sequencer in the pixel clock domain.
// Starts physics, then the environment stream. It then waits for blanking and
// issues a one-cycle swap strobe, so render-side registers only ever latch a
// complete frame.
// Optional watchdog: define FRAME_SCHEDULER_WATCHDOG_EN to abort frames that
// stay active for TIMEOUT_CYCLES cycles.
module frame_scheduler #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int COUNT_BITS     = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  new_frame_in,
  input  logic                  active_draw_in,
  output logic                  phys_start_out,
  input  logic                  phys_done_in,
  output logic                  env_start_out,
  input  logic                  env_done_in,
  output logic                  swap_out,
  output logic                  busy_out,
  output logic [COUNT_BITS-1:0] frames_out,
  output logic [COUNT_BITS-1:0] overruns_out,
  output logic [COUNT_BITS-1:0] timeouts_out
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PHYS       = 3'd1,
    ENV        = 3'd2,
    WAIT_BLANK = 3'd3,
    SWAP       = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  phys_start_q, phys_start_d;
  logic                  env_start_q, env_start_d;
  logic                  swap_q, swap_d;
  logic                  busy_q, busy_d;
  logic [COUNT_BITS-1:0] frames_q, frames_d;
  logic [COUNT_BITS-1:0] overruns_q, overruns_d;
  logic                  overrun_evt;
  logic                  timeout_hit;

  // Saturating increment used by the overrun and timeout statistics.
  function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef FRAME_SCHEDULER_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  wd_run;
  logic [COUNT_BITS-1:0] timeouts_q, timeouts_d;

  // Watchdog counts active-frame cycles and fires on its last allowed cycle.
  always_comb begin
    wd_run      = (state_q == PHYS) || (state_q == ENV) || (state_q == WAIT_BLANK);
    timeout_hit = wd_run && (wd_q == WD_LAST);
    wd_d        = (wd_run && !timeout_hit) ? wd_q + 1'b1 : '0;
    timeouts_d  = timeout_hit ? sat_inc(timeouts_q) : timeouts_q;
  end

  // Watchdog counter and timeout statistic registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wd_q       <= '0;
      timeouts_q <= '0;
    end else begin
      wd_q       <= wd_d;
      timeouts_q <= timeouts_d;
    end
  end

  assign timeouts_out = timeouts_q;
`else
  assign timeout_hit  = 1'b0;
  assign timeouts_out = '0;
`endif

  // Next state, registered-output next values and counter updates.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (new_frame_in) state_d = PHYS;
      // A done pulse coinciding with our own start pulse belongs to no frame.
      PHYS:       if (phys_done_in && !phys_start_q) state_d = ENV;
      ENV:        if (env_done_in) state_d = WAIT_BLANK;
      WAIT_BLANK: if (!active_draw_in) state_d = SWAP;
      SWAP:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    if (timeout_hit) state_d = IDLE;

    phys_start_d = (state_d == PHYS) && (state_q == IDLE);
    env_start_d  = (state_d == ENV) && (state_q == PHYS);
    swap_d       = (state_d == SWAP);
    busy_d       = (state_d != IDLE);

    overrun_evt  = new_frame_in && (state_q != IDLE);
    overruns_d   = overrun_evt ? sat_inc(overruns_q) : overruns_q;
    frames_d     = (state_q == SWAP) ? frames_q + 1'b1 : frames_q;
  end

  // State, pulse outputs and statistics registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      phys_start_q <= 1'b0;
      env_start_q  <= 1'b0;
      swap_q       <= 1'b0;
      busy_q       <= 1'b0;
      frames_q     <= '0;
      overruns_q   <= '0;
    end else begin
      state_q      <= state_d;
      phys_start_q <= phys_start_d;
      env_start_q  <= env_start_d;
      swap_q       <= swap_d;
      busy_q       <= busy_d;
      frames_q     <= frames_d;
      overruns_q   <= overruns_d;
    end
  end

  assign phys_start_out = phys_start_q;
  assign env_start_out  = env_start_q;
  assign swap_out       = swap_q;
  assign busy_out       = busy_q;
  assign frames_out     = frames_q;
  assign overruns_out   = overruns_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: frame-level reference model pushes
// expected pulse events; a monitor pops them as the DUT emits pulses.
module tb_frame_scheduler;

  localparam int TMO = 50;
  localparam int CB  = 3;
  localparam int CMAX = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          rst_in;
  logic          new_frame_in, active_draw_in, phys_done_in, env_done_in;
  logic          phys_start_out, env_start_out, swap_out, busy_out;
  logic [CB-1:0] frames_out, overruns_out, timeouts_out;

  frame_scheduler #(.TIMEOUT_CYCLES(TMO), .COUNT_BITS(CB)) dut (
    .clk_in(clk), .rst_in(rst_in), .new_frame_in(new_frame_in),
    .active_draw_in(active_draw_in), .phys_start_out(phys_start_out),
    .phys_done_in(phys_done_in), .env_start_out(env_start_out),
    .env_done_in(env_done_in), .swap_out(swap_out), .busy_out(busy_out),
    .frames_out(frames_out), .overruns_out(overruns_out),
    .timeouts_out(timeouts_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;   // 0 phys start, 1 env start, 2 swap
    int cyc;
    int frames;
    int ovr;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_frames = 0, exp_ovr = 0, exp_tmo = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int sat(int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Monitor: every pulse the DUT emits must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   k;
    if (!rst_in && (phys_start_out || env_start_out || swap_out)) begin
      chk("pulse_overlap", int'(phys_start_out) + int'(env_start_out) + int'(swap_out), 1);
      k = swap_out ? 2 : (env_start_out ? 1 : 0);
      if (q.size() == 0) begin
        chk("unexpected_pulse_kind", k, -1);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", k, e.kind);
        chk("pulse_cycle", cyc, e.cyc);
        chk("busy_on_pulse", int'(busy_out), 1);
        if (k == 2) begin
          chk("frames_at_swap", int'(frames_out), e.frames);
          chk("overruns_at_swap", int'(overruns_out), e.ovr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    new_frame_in = 0; phys_done_in = 0; env_done_in = 0; active_draw_in = 0;
  endtask

  // One frame: physics done dp cycles after start, env done de cycles after
  // env start, db cycles of visible region in WAIT_BLANK. o1/o2 are offsets
  // (from the new_frame cycle) of extra new_frame pulses, -1 for none.
  task automatic run_frame(int dp, int de, int db, int o1, int o2, bit stray);
    int n, tm, tk, tj;
    exp_t e;
    if (stray) begin
      phys_done_in = 1; env_done_in = 1;
      step();
      clear_inputs();
    end
    n  = cyc;
    tm = 1 + dp;
    tk = tm + 1 + de;
    tj = tk + 1 + db;
    if (o1 >= 1 && o1 <= tj) exp_ovr = sat(exp_ovr);
    if (o2 >= 1 && o2 <= tj) exp_ovr = sat(exp_ovr);
    e = '{0, n + 1, 0, 0};              q.push_back(e);
    e = '{1, n + tm + 1, 0, 0};         q.push_back(e);
    e = '{2, n + tj + 1, exp_frames, exp_ovr}; q.push_back(e);
    exp_frames = (exp_frames + 1) % (CMAX + 1);
    if (o1 == tj + 1) exp_ovr = sat(exp_ovr);
    if (o2 == tj + 1) exp_ovr = sat(exp_ovr);
    for (int t = 0; t <= tj + 1; t++) begin
      new_frame_in = (t == 0) || (t == o1) || (t == o2);
      phys_done_in = (t == tm) || (stray && t == 1);
      env_done_in  = (t == tk) || (stray && t == 1);
      if (t > tk && t < tj)  active_draw_in = 1;
      else if (t == tj)      active_draw_in = 0;
      else                   active_draw_in = 1'($urandom_range(0, 1));
      step();
    end
    clear_inputs();
    chk("busy_after_swap", int'(busy_out), 0);
    chk("frames_after_swap", int'(frames_out), exp_frames);
    chk("overruns_after_frame", int'(overruns_out), exp_ovr);
  endtask

  initial begin
    int dp, de, db, tj, o1, o2;
    exp_t e;
    clear_inputs();
    rst_in = 1;
    step(); step();
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_swap", int'(swap_out), 0);
    chk("rst_frames", int'(frames_out), 0);
    chk("rst_overruns", int'(overruns_out), 0);
    chk("rst_timeouts", int'(timeouts_out), 0);
    rst_in = 0;
    step(); step();

    // Nominal frame with overruns during PHYS and in the SWAP cycle.
    run_frame(9, 19, 0, 5, 32, 1'b0);
    chk("nominal_overruns", int'(overruns_out), 2);
    step();
    // Minimum latency: swap five cycles after new_frame.
    run_frame(1, 0, 0, -1, -1, 1'b0);
    step();
    // Blank gating: held in WAIT_BLANK while the visible region lasts.
    run_frame(2, 2, 25, -1, -1, 1'b0);
    step();
    // Stray dones in IDLE and PHYS (including physics done in its start cycle).
    run_frame(3, 1, 2, -1, -1, 1'b1);
    step();

    for (int i = 0; i < 30; i++) begin
      dp = $urandom_range(1, 8);
      de = $urandom_range(0, 8);
      db = $urandom_range(0, 8);
      tj = 1 + dp + 1 + de + 1 + db;
      o1 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, tj)) : -1;
      o2 = ($urandom_range(0, 1) == 1) ? tj + 1 : -1;
      run_frame(dp, de, db, o1, o2, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) step();
    end

    // Asynchronous reset in the middle of ENV: no swap afterwards.
    begin
      int n;
      n = cyc;
      e = '{0, n + 1, 0, 0}; q.push_back(e);
      new_frame_in = 1; step(); clear_inputs();
      step();
      phys_done_in = 1; step(); clear_inputs();
      chk("env_start_before_reset", int'(env_start_out), 1);
      #2 rst_in = 1;
      #1;
      chk("async_rst_busy", int'(busy_out), 0);
      chk("async_rst_env_start", int'(env_start_out), 0);
      chk("async_rst_frames", int'(frames_out), 0);
      chk("async_rst_overruns", int'(overruns_out), 0);
      step();
      rst_in = 0;
      exp_frames = 0; exp_ovr = 0; exp_tmo = 0;
      env_done_in = 1; active_draw_in = 0; step(); clear_inputs();
      repeat (5) step();
      chk("post_reset_busy", int'(busy_out), 0);
      chk("post_reset_frames", int'(frames_out), 0);
    end

`ifdef FRAME_SCHEDULER_WATCHDOG_EN
    // Physics never completes: watchdog returns to IDLE TMO cycles after PHYS entry.
    begin
      int n;
      n = cyc;
      e = '{0, n + 1, 0, 0}; q.push_back(e);
      new_frame_in = 1; step(); clear_inputs();
      while (cyc < n + TMO) step();
      chk("wd_busy_last_cycle", int'(busy_out), 1);
      step();
      exp_tmo = sat(exp_tmo);
      chk("wd_busy_after", int'(busy_out), 0);
      chk("wd_timeouts", int'(timeouts_out), exp_tmo);
      chk("wd_frames", int'(frames_out), exp_frames);
      step();
    end
`endif
    run_frame(2, 1, 1, -1, -1, 1'b0);
    repeat (3) step();
    chk("final_timeouts", int'(timeouts_out), exp_tmo);
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
